div_seq_ctrl: RTL and testbench

//   Multi-cycle sequencer for the CPU's 32-bit DIV operation. Latches operands on a start

---
 rtl/div_seq_ctrl.sv | 92 +++++++++
 tb/tb_div_seq_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle restoring divider sequencer with sign handling and divide-by-zero flag
module div_seq_ctrl #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dz
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   dvd, dvs, mag_dvs, mag_dvd_c, mag_dvs_c;
    logic [2*WIDTH-1:0] a, a_nx;
    logic [WIDTH:0]     t;
    logic [CW-1:0]      cnt;
    logic               neg_q, neg_r, dvd_neg, dvs_neg, accept, last;

    // next state, status outputs and one shift-subtract step; the shifted-out bit joins the trial subtract
    always_comb begin
        accept    = start && (state == IDLE || state == DONE);
        last      = cnt == CW'(WIDTH - 1);
        busy      = state == PREP || state == ITER || state == FIX;
        done      = state == DONE;
        dvd_neg   = SIGNED && dvd[WIDTH-1];
        dvs_neg   = SIGNED && dvs[WIDTH-1];
        mag_dvd_c = dvd_neg ? -dvd : dvd;
        mag_dvs_c = dvs_neg ? -dvs : dvs;
        t         = a[2*WIDTH-1:WIDTH-1] - {1'b0, mag_dvs};
        a_nx      = t[WIDTH] ? {a[2*WIDTH-2:0], 1'b0} : {t[WIDTH-1:0], a[WIDTH-2:0], 1'b1};
        state_nx  = accept           ? PREP :
                    state == PREP    ? (dvs == '0 ? DONE : ITER) :
                    state == ITER    ? (last ? FIX : ITER) :
                    state == FIX     ? DONE :
                    state == DONE    ? IDLE : state;
    end

    // state register
    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_nx;
    end

    // operand latch, iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (clr) begin
            q       <= '0;
            r       <= '0;
            dz      <= 1'b0;
            cnt     <= '0;
            a       <= '0;
            dvd     <= '0;
            dvs     <= '0;
            mag_dvs <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (accept) begin
            dvd <= dividend;
            dvs <= divisor;
            q   <= '0;
            r   <= '0;
            dz  <= 1'b0;
        end else if (state == PREP) begin
            if (dvs == '0) begin
                q  <= '1;
                r  <= dvd;
                dz <= 1'b1;
            end else begin
                a       <= {{WIDTH{1'b0}}, mag_dvd_c};
                mag_dvs <= mag_dvs_c;
                neg_q   <= dvd_neg ^ dvs_neg;
                neg_r   <= dvd_neg;
                cnt     <= '0;
            end
        end else if (state == ITER) begin
            a   <= a_nx;
            cnt <= cnt + 1'b1;
        end else if (state == FIX) begin
            q <= neg_q ? -a[WIDTH-1:0] : a[WIDTH-1:0];
            r <= neg_r ? -a[2*WIDTH-1:WIDTH] : a[2*WIDTH-1:WIDTH];
        end
    end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed scoreboard bench for signed and unsigned div_seq_ctrl instances
module tb_div_seq_ctrl;
    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } res_t;

    logic        clk = 1'b0;
    logic        clr, start;
    logic [31:0] dividend, divisor;
    logic        busy0, done0, dz0, busy1, done1, dz1;
    logic [31:0] q0, r0, q1, r1;
    res_t        sb0[$], sb1[$];
    int          checks = 0, errors = 0, cnt = 0;

    always #5 clk = ~clk;

    div_seq_ctrl #(.WIDTH(32), .SIGNED(1)) u0 (
        .clk(clk), .clr(clr), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy0), .done(done0), .q(q0), .r(r0), .dz(dz0)
    );

    div_seq_ctrl #(.WIDTH(32), .SIGNED(0)) u1 (
        .clk(clk), .clr(clr), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy1), .done(done1), .q(q1), .r(r1), .dz(dz1)
    );

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input bit sg);
        res_t e;
        if (b == 32'd0) begin
            e.q = '1; e.r = a; e.dz = 1'b1;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = a; e.r = '0; e.dz = 1'b0;
        end else if (sg) begin
            e.q = $signed(a) / $signed(b); e.r = $signed(a) % $signed(b); e.dz = 1'b0;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        if (busy0) cnt++;
        tick();
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start = 1'b0;
        cnt   = 0;
        if (push) begin
            sb0.push_back(model(a, b, 1'b1));
            sb1.push_back(model(a, b, 1'b0));
        end
    endtask

    task automatic finish_op(input string tag, input int exp_busy);
        int   g = 0;
        res_t e;
        while (done0 !== 1'b1 && g < 100) begin
            cyc();
            g++;
        end
        chk({tag, "_done0"}, 32'(done0), 32'd1);
        chk({tag, "_done1"}, 32'(done1), 32'd1);
        chk({tag, "_busy_with_done"}, 32'(busy0), 32'd0);
        chk({tag, "_busy_cycles"}, cnt, exp_busy);
        chk({tag, "_sb_nonempty"}, 32'(sb0.size() > 0 && sb1.size() > 0), 32'd1);
        if (sb0.size() > 0) begin
            e = sb0.pop_front();
            chk({tag, "_q_s"}, q0, e.q);
            chk({tag, "_r_s"}, r0, e.r);
            chk({tag, "_dz_s"}, 32'(dz0), 32'(e.dz));
        end
        if (sb1.size() > 0) begin
            e = sb1.pop_front();
            chk({tag, "_q_u"}, q1, e.q);
            chk({tag, "_r_u"}, r1, e.r);
            chk({tag, "_dz_u"}, 32'(dz1), 32'(e.dz));
        end
    endtask

    task automatic idle_check(input string tag, input logic [31:0] eq, input logic [31:0] er);
        tick();
        chk({tag, "_idle_busy"}, 32'(busy0), 32'd0);
        chk({tag, "_idle_done"}, 32'(done0), 32'd0);
        chk({tag, "_held_q"}, q0, eq);
        chk({tag, "_held_r"}, r0, er);
    endtask

    initial begin
        bit fired;
        clr      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) tick();
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_q", q0, 32'd0);
        chk("rst_r", r0, 32'd0);
        chk("rst_dz", 32'(dz0), 32'd0);
        clr = 1'b0;
        tick();

        issue(32'd100, 32'd7, 1'b1);
        finish_op("t1_100_7", 34);
        idle_check("t1", 32'd14, 32'd2);

        issue(-32'sd100, 32'd7, 1'b1);
        finish_op("t2_m100_7", 34);
        issue(32'd100, -32'sd7, 1'b1);
        finish_op("t2_100_m7", 34);
        idle_check("t2", 32'hFFFF_FFF2, 32'd2);

        issue(32'd5, 32'd0, 1'b1);
        finish_op("t3_div0", 1);
        idle_check("t3", 32'hFFFF_FFFF, 32'd5);

        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        finish_op("t4_ovf", 34);

        issue(32'd100, 32'd7, 1'b1);
        repeat (9) cyc();
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        cyc();
        start = 1'b0;
        finish_op("t5_ignored", 34);
        issue(32'd9, 32'd3, 1'b1);
        chk("t5_clear_q", q0, 32'd0);
        chk("t5_clear_r", r0, 32'd0);
        finish_op("t5_b2b", 34);

        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom_range(1, 1000);
            if (i[0]) b = -b;
            issue(a, b, 1'b1);
            finish_op("rand", 34);
        end

        tick();
        issue(32'd100, 32'd7, 1'b0);
        repeat (19) cyc();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t6_busy", 32'(busy0), 32'd0);
        chk("t6_done", 32'(done0), 32'd0);
        chk("t6_q", q0, 32'd0);
        chk("t6_r", r0, 32'd0);
        fired = 1'b0;
        repeat (40) begin
            if (done0 || done1) fired = 1'b1;
            tick();
        end
        chk("t6_no_done", 32'(fired), 32'd0);
        issue(32'd7, 32'd2, 1'b1);
        finish_op("t6_7_2", 34);

        chk("sb_drained", 32'(sb0.size() + sb1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
